// File: rtl/prog_timer.sv
// prog_timer: programmable interval timer with prescaler, one-shot/auto-reload
// modes, stop/restart control and a one-cycle READY expiry strobe.
module prog_timer #(
    parameter int W        = 16,
    parameter int PRESCALE = 1
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         START,
    input  logic         STOP,
    input  logic         RELOAD,
    input  logic [W-1:0] PERIOD,
    output logic         READY,
    output logic         BUSY,
    output logic [W-1:0] COUNT
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  cnt, cnt_n, per, per_n;
    logic [PW-1:0] pre, pre_n;
    logic          mode, mode_n;
    logic          go, tick;

    assign go   = START && PERIOD != '0;
    assign tick = state == RUN && pre == PW'(PRESCALE - 1);

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state <= IDLE;
            cnt   <= '0;
            per   <= '0;
            pre   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            per   <= per_n;
            pre   <= pre_n;
            mode  <= mode_n;
        end
    end

    // STOP beats START beats tick; a valid START rearms from any state
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        per_n   = per;
        pre_n   = pre;
        mode_n  = mode;
        if (STOP) begin
            state_n = IDLE;
            cnt_n   = '0;
            pre_n   = '0;
        end else if (go) begin
            state_n = RUN;
            per_n   = PERIOD;
            mode_n  = RELOAD;
            cnt_n   = '0;
            pre_n   = '0;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    pre_n = tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        if (cnt == per - 1'b1)
                            state_n = DONE;
                        else
                            cnt_n = cnt + 1'b1;
                    end
                end
                DONE: begin
                    state_n = mode ? RUN : IDLE;
                    cnt_n   = '0;
                    pre_n   = '0;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pre_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        READY = state == DONE;
        BUSY  = state != IDLE;
        COUNT = cnt;
    end
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: checks prog_timer at PRESCALE=1 and PRESCALE=4 against
// directed timing expectations and an elapsed-cycle arithmetic model.
module tb_prog_timer;
    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         N_RESET = 1'b0;
    logic         START = 1'b0, STOP = 1'b0, RELOAD = 1'b0;
    logic [W-1:0] PERIOD = '0;
    logic         r1, b1, r4, b4;
    logic [W-1:0] c1, c4;

    int pass = 0, total = 0;

    // model: per instance, armed flag, latched period/mode, cycles since arming
    int ps[2] = '{1, 4};
    bit m_act[2];
    bit m_mode[2];
    int m_per[2];
    int m_e[2];

    prog_timer #(.W(W), .PRESCALE(1)) u1 (
        .CLK(CLK), .N_RESET(N_RESET), .START(START), .STOP(STOP), .RELOAD(RELOAD),
        .PERIOD(PERIOD), .READY(r1), .BUSY(b1), .COUNT(c1)
    );

    prog_timer #(.W(W), .PRESCALE(4)) u4 (
        .CLK(CLK), .N_RESET(N_RESET), .START(START), .STOP(STOP), .RELOAD(RELOAD),
        .PERIOD(PERIOD), .READY(r4), .BUSY(b4), .COUNT(c4)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_mode[k] = 0; m_per[k] = 0; m_e[k] = 0;
        end
    endfunction

    function automatic void model_step(int k);
        bit go = START && PERIOD != 0;
        if (!N_RESET) begin
            m_act[k] = 0; m_e[k] = 0;
        end else if (STOP) begin
            m_act[k] = 0; m_e[k] = 0;
        end else if (go) begin
            m_act[k] = 1; m_per[k] = PERIOD; m_mode[k] = RELOAD; m_e[k] = 0;
        end else if (m_act[k]) begin
            if (m_e[k] == m_per[k] * ps[k]) begin
                m_e[k] = 0;
                m_act[k] = m_mode[k];
            end else
                m_e[k]++;
        end
    endfunction

    function automatic logic [W+1:0] model_out(int k);
        bit rdy = m_act[k] && m_e[k] == m_per[k] * ps[k];
        int cnt = !m_act[k] ? 0 : rdy ? m_per[k] - 1 : m_e[k] / ps[k];
        return {rdy, m_act[k], W'(cnt)};
    endfunction

    task automatic cycle();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle_both();
        START = 0; STOP = 1;
        cycle();
        STOP = 0;
    endtask

    task automatic test_reset();
        N_RESET = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({r1, b1, c1, r4, b4, c4} !== '0)
                $display("FAIL reset: r1=%b b1=%b c1=%0d r4=%b b4=%b c4=%0d, all must be 0",
                         r1, b1, c1, r4, b4, c4);
            else pass++;
        end
        @(negedge CLK);
        N_RESET = 1;
        cycle();
    endtask

    task automatic test_oneshot();
        idle_both();
        PERIOD = 5; RELOAD = 0; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c <= 8; c++) begin
            logic [W-1:0] ec = c <= 5 ? W'(c - 1) : c == 6 ? W'(4) : '0;
            total++;
            if ({r1, b1, c1} !== {c == 6, c <= 6, ec})
                $display("FAIL oneshot c%0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                         c, r1, b1, c1, c == 6, c <= 6, ec);
            else pass++;
            cycle();
        end
    endtask

    task automatic test_autoreload();
        idle_both();
        PERIOD = 3; RELOAD = 1; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c <= 18; c++) begin
            bit er = c == 4 || c == 8 || c == 12;
            total++;
            if (r1 !== er || (c >= 14 && b1 !== 1'b0))
                $display("FAIL autoreload c%0d: ready=%b busy=%b, want ready=%b", c, r1, b1, er);
            else pass++;
            STOP = c == 13;
            cycle();
        end
        STOP = 0;
    endtask

    task automatic test_prescaler();
        idle_both();
        PERIOD = 2; RELOAD = 0; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c <= 10; c++) begin
            logic [W-1:0] ec = c <= 4 ? '0 : c <= 9 ? W'(1) : '0;
            total++;
            if ({r4, b4, c4} !== {c == 9, c <= 9, ec})
                $display("FAIL prescaler c%0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                         c, r4, b4, c4, c == 9, c <= 9, ec);
            else pass++;
            cycle();
        end
    endtask

    task automatic test_restart();
        idle_both();
        PERIOD = 10; RELOAD = 0; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c <= 8; c++) begin
            logic [W-1:0] ec = c <= 4 ? W'(c - 1) : c == 5 ? '0 : c <= 7 ? W'(1) : '0;
            total++;
            if ({r1, b1, c1} !== {c == 7, c <= 7, ec})
                $display("FAIL restart c%0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                         c, r1, b1, c1, c == 7, c <= 7, ec);
            else pass++;
            START = c == 4;
            PERIOD = c == 4 ? 2 : 10;
            cycle();
        end
        START = 0;
        PERIOD = 6; START = 1;
        cycle();
        PERIOD = 4; STOP = 1;
        cycle();
        START = 0; STOP = 0;
        total++;
        if (b1 !== 1'b0 || c1 !== '0)
            $display("FAIL collision: busy=%b count=%0d, want 0 0", b1, c1);
        else pass++;
    endtask

    task automatic test_invalid();
        idle_both();
        PERIOD = 0; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({r1, b1, r4, b4} !== 4'b0)
                $display("FAIL invalid c%0d: r1=%b b1=%b r4=%b b4=%b, want 0", c, r1, b1, r4, b4);
            else pass++;
            cycle();
        end
        STOP = 1;
        cycle();
        STOP = 0;
        total++;
        if ({r1, b1, c1} !== '0)
            $display("FAIL idle_stop: ready=%b busy=%b count=%0d, want 0", r1, b1, c1);
        else pass++;
        PERIOD = 1; START = 1;
        cycle();
        START = 0;
        total++;
        if ({r1, b1, c1} !== {1'b0, 1'b1, W'(0)})
            $display("FAIL period1 run: ready=%b busy=%b count=%0d, want 0 1 0", r1, b1, c1);
        else pass++;
        cycle();
        total++;
        if ({r1, b1, c1} !== {1'b1, 1'b1, W'(0)})
            $display("FAIL period1 done: ready=%b busy=%b count=%0d, want 1 1 0", r1, b1, c1);
        else pass++;
    endtask

    task automatic test_async_reset();
        idle_both();
        PERIOD = 8; RELOAD = 0; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c < 4; c++) cycle();
        total++;
        if (b1 !== 1'b1 || c1 !== W'(3))
            $display("FAIL pre_reset: busy=%b count=%0d, want 1 3", b1, c1);
        else pass++;
        #2;
        N_RESET = 0;
        model_reset();
        #1;
        total++;
        if ({r1, b1, c1, r4, b4, c4} !== '0)
            $display("FAIL async_reset: b1=%b c1=%0d b4=%b c4=%0d, want 0", b1, c1, b4, c4);
        else pass++;
        @(negedge CLK);
        N_RESET = 1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            total++;
            if ({r1, b1, r4, b4} !== 4'b0)
                $display("FAIL post_reset c%0d: r1=%b b1=%b r4=%b b4=%b, want 0", c, r1, b1, r4, b4);
            else pass++;
        end
    endtask

    task automatic test_max_period();
        idle_both();
        PERIOD = '1; RELOAD = 0; START = 1;
        cycle();
        START = 0;
        for (int c = 1; c <= 65537; c++) begin
            if (c == 65535 || c == 65536 || c == 65537) begin
                logic [2+W-1:0] e = c == 65535 ? {1'b0, 1'b1, 16'hFFFE} :
                                    c == 65536 ? {1'b1, 1'b1, 16'hFFFE} : '0;
                total++;
                if ({r1, b1, c1} !== e)
                    $display("FAIL maxperiod c%0d: ready=%b busy=%b count=%h, want %b %b %h",
                             c, r1, b1, c1, e[W+1], e[W], e[W-1:0]);
                else pass++;
            end
            PERIOD = W'($urandom_range(1, 65535));
            cycle();
        end
    endtask

    task automatic test_random();
        idle_both();
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                logic [W+1:0] got = k == 0 ? {r1, b1, c1} : {r4, b4, c4};
                logic [W+1:0] exp = model_out(k);
                total++;
                if (got !== exp)
                    $display("FAIL random i%0d ps%0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                             i, ps[k], got[W+1], got[W], got[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
                else pass++;
            end
            START  = $urandom_range(0, 5) == 0;
            STOP   = $urandom_range(0, 13) == 0;
            RELOAD = 1'($urandom);
            PERIOD = $urandom_range(0, 7) == 0 ? '0 : W'($urandom_range(1, 6));
            cycle();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_prescaler();
        test_restart();
        test_invalid();
        test_async_reset();
        test_max_period();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
